// File: rtl/ycbcr_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : ycbcr_accum_stage
// Purpose  : Per-channel frame accumulator with offset, round, clamp and
//            valid/ready output for the colour-conversion pipeline.
// Revision : 1.0  initial release
// ============================================================================
module ycbcr_accum_stage #(
  parameter int                   NCH       = 3,
  parameter int                   IN_W      = 17,
  parameter int                   ACC_W     = 20,
  parameter int                   FRAC_BITS = 8,
  parameter int                   OUT_W     = 8,
  parameter logic [NCH*ACC_W-1:0] OFFSETS   = {20'd32768, 20'd32768, 20'd0},
  parameter bit                   ROUND     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             status_i,
  input  logic [NCH*IN_W-1:0]    data_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*OUT_W-1:0]   data_o,
  output logic [NCH-1:0]         sat_o,
  output logic                   err_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic signed [ACC_W:0] RND_C =
    ROUND ? (ACC_W+1)'(2 ** (FRAC_BITS - 1)) : (ACC_W+1)'(0);

  state_t                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q [NCH];
  logic [ACC_W-1:0]       acc_d [NCH];
  logic                   out_valid_q, out_valid_d;
  logic [NCH*OUT_W-1:0]   data_q, data_d;
  logic [NCH-1:0]         sat_q, sat_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   restart;
  logic                   emit;
  logic                   proto_err;
  logic [ACC_W-1:0]       acc_sum [NCH];
  logic [OUT_W-1:0]       ch_out  [NCH];
  logic                   ch_sat  [NCH];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Status 0 and 3 always open a fresh frame; from IDLE every beat does.
  assign restart   = (state_q == ST_IDLE) || (status_i[0] == status_i[1]);
  assign emit      = status_i[1];
  assign proto_err = (state_q == ST_IDLE) ? (status_i[0] != status_i[1])
                                          : (status_i[0] == status_i[1]);

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      logic [ACC_W-1:0]        base;
      logic [ACC_W-1:0]        sext;
      logic signed [ACC_W:0]   t;
      logic signed [ACC_W:0]   s;
      logic                    over;

      assign base = restart ? OFFSETS[c*ACC_W +: ACC_W] : acc_q[c];
      assign sext = {{(ACC_W-IN_W){data_i[c*IN_W+IN_W-1]}}, data_i[c*IN_W +: IN_W]};
      assign acc_sum[c] = base + sext;

      // One extra bit keeps the rounding add from wrapping.
      assign t    = $signed({acc_sum[c][ACC_W-1], acc_sum[c]}) + RND_C;
      assign s    = t >>> FRAC_BITS;
      assign over = |s[ACC_W-1:OUT_W];

      assign ch_sat[c] = s[ACC_W] | over;
      assign ch_out[c] = s[ACC_W] ? '0 : (over ? '1 : s[OUT_W-1:0]);
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    sat_d       = sat_q;
    err_d       = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      acc_d[i] = acc_q[i];
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      for (int i = 0; i < NCH; i++) begin
        acc_d[i] = acc_sum[i];
      end
      state_d = emit ? ST_IDLE : ST_ACCUM;
      err_d   = proto_err;
      if (emit) begin
        out_valid_d = 1'b1;
        for (int i = 0; i < NCH; i++) begin
          data_d[i*OUT_W +: OUT_W] = ch_out[i];
          sat_d[i]                 = ch_sat[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sat_q       <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign data_o    = data_q;
  assign sat_o     = sat_q;
  assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ycbcr_accum_stage
// Purpose  : Directed and random checks of ycbcr_accum_stage (ROUND 1 and 0).
// Revision : 1.0  initial release
// ============================================================================
module tb_ycbcr_accum_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  status_i = 2'd0;
  logic [50:0] data_i = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_a, out_valid_a, err_a;
  logic [23:0] data_a;
  logic [2:0]  sat_a;
  logic        in_ready_b, out_valid_b, err_b;
  logic [23:0] data_b;
  logic [2:0]  sat_b;

  always #5 clk = ~clk;

  ycbcr_accum_stage dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .status_i(status_i), .data_i(data_i), .out_valid(out_valid_a),
    .out_ready(out_ready), .data_o(data_a), .sat_o(sat_a), .err_o(err_a)
  );

  ycbcr_accum_stage #(.ROUND(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .status_i(status_i), .data_i(data_i), .out_valid(out_valid_b),
    .out_ready(out_ready), .data_o(data_b), .sat_o(sat_b), .err_o(err_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: frame sums kept as plain integers.
  int          offs_tab [3] = '{0, 32768, 32768};
  int          m_sum [3];
  bit          m_open, m_valid, m_err, last_acc;
  logic [23:0] m_data_r, m_data_t;
  logic [2:0]  m_sat_r, m_sat_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx17(input logic [16:0] v);
    return int'($signed(v));
  endfunction

  function automatic int wrap20(input int v);
    int a;
    a = v & 32'h000F_FFFF;
    if (a >= 524288) a -= 1048576;
    return a;
  endfunction

  function automatic void model_out(input bit rnd, output logic [23:0] d, output logic [2:0] s);
    int t, q;
    d = '0;
    s = '0;
    for (int c = 0; c < 3; c++) begin
      t = m_sum[c] + (rnd ? 128 : 0);
      q = t >>> 8;
      if (q < 0) begin
        d[c*8 +: 8] = 8'd0;
        s[c] = 1'b1;
      end else if (q > 255) begin
        d[c*8 +: 8] = 8'd255;
        s[c] = 1'b1;
      end else begin
        d[c*8 +: 8] = q[7:0];
      end
    end
  endfunction

  task automatic check_outputs();
    check("out_valid",    out_valid_a, m_valid);
    check("out_valid_r0", out_valid_b, m_valid);
    check("err",          err_a,       m_err);
    check("err_r0",       err_b,       m_err);
    check("data",         data_a,      m_data_r);
    check("data_r0",      data_b,      m_data_t);
    check("sat",          sat_a,       m_sat_r);
    check("sat_r0",       sat_b,       m_sat_t);
  endtask

  // One clock: check in_ready, advance the model, clock, check outputs.
  task automatic tick();
    bit fresh;
    #1;
    check("in_ready",    in_ready_a, !m_valid || out_ready);
    check("in_ready_r0", in_ready_b, !m_valid || out_ready);
    last_acc = in_valid && (!m_valid || out_ready);
    m_err = 1'b0;
    if (m_valid && out_ready) m_valid = 1'b0;
    if (last_acc) begin
      fresh = !m_open || status_i == 2'd0 || status_i == 2'd3;
      m_err = m_open ? (status_i == 2'd0 || status_i == 2'd3)
                     : (status_i == 2'd1 || status_i == 2'd2);
      for (int c = 0; c < 3; c++) begin
        if (fresh) m_sum[c] = offs_tab[c];
        m_sum[c] = wrap20(m_sum[c] + sx17(data_i[c*17 +: 17]));
      end
      if (status_i[1]) begin
        model_out(1'b1, m_data_r, m_sat_r);
        model_out(1'b0, m_data_t, m_sat_t);
        m_valid = 1'b1;
        m_open  = 1'b0;
      end else begin
        m_open = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [1:0] st, input int y, input int cb, input int cr);
    in_valid = 1'b1;
    status_i = st;
    data_i   = {17'(cr), 17'(cb), 17'(y)};
  endtask

  task automatic beat(input logic [1:0] st, input int y, input int cb, input int cr);
    int n;
    n = 0;
    drive(st, y, cb, cr);
    do begin
      tick();
      n++;
    end while (!last_acc && n < 40);
    check("beat_accept", last_acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    m_open = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    m_data_r = '0; m_data_t = '0; m_sat_r = '0; m_sat_t = '0;
    for (int c = 0; c < 3; c++) m_sum[c] = 0;
    check_outputs();
    check("rst_in_ready", in_ready_a, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    do_reset();

    // Single beat with default offsets
    beat(2'd3, 19200, -2560, 0);
    check("single_data", data_a, {8'd128, 8'd118, 8'd75});
    check("single_sat",  sat_a, 3'b000);
    check("single_err",  err_a, 1'b0);
    tick();

    // Three-beat frame, both rounding modes
    beat(2'd0, 4096, 0, 0);
    beat(2'd1, 4096, 0, 0);
    check("frame_no_early_valid", out_valid_a, 1'b0);
    beat(2'd2, 128, 0, 0);
    check("frame_round",    data_a, {8'd128, 8'd128, 8'd33});
    check("frame_truncate", data_b[7:0], 8'd32);
    tick();
    check("frame_single_pulse", out_valid_a, 1'b0);

    // Saturation both directions
    beat(2'd3, -512, 65535, 0);
    check("sat_data", data_a, {8'd128, 8'd255, 8'd0});
    check("sat_flags", sat_a, 3'b011);

    // Backpressure: result pending, input stalled
    out_ready = 1'b0;
    drive(2'd0, 4096, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", data_a, {8'd128, 8'd255, 8'd0});
      check("stall_ready", in_ready_a, 1'b0);
    end
    out_ready = 1'b1;
    beat(2'd0, 4096, 0, 0);
    beat(2'd1, 4096, 0, 0);
    beat(2'd2, 128, 0, 0);
    check("bp_result", data_a, {8'd128, 8'd128, 8'd33});

    // Status 1 from IDLE loads offset and flags error
    tick();
    beat(2'd1, 256, 0, 0);
    check("err_mid_from_idle", err_a, 1'b1);
    beat(2'd2, 256, 0, 0);
    check("err_mid_result", data_a, {8'd128, 8'd128, 8'd2});

    // Status 0 inside a frame discards the partial sum
    beat(2'd0, 9999, 0, 0);
    beat(2'd0, 256, 0, 0);
    check("err_restart", err_a, 1'b1);
    beat(2'd2, 0, 0, 0);
    check("restart_result", data_a, {8'd128, 8'd128, 8'd1});

    // Reset in the middle of a frame
    beat(2'd0, 5000, 0, 0);
    beat(2'd1, 5000, 0, 0);
    do_reset();
    beat(2'd3, 256, 0, 0);
    check("post_reset_data", data_a, {8'd128, 8'd128, 8'd1});
    check("post_reset_err",  err_a, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (m_open) status_i = (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'($urandom_range(0, 3));
      else        status_i = (r < 5) ? 2'd0 : (r < 9) ? 2'd3 : 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      data_i    = {17'($urandom_range(0, 131071)), 17'($urandom_range(0, 131071)),
                   17'($urandom_range(0, 131071))};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
